// File: rtl/ulut_array.sv
// Array of CH universal K-input gates. Each channel's truth table comes from a serially
// loaded configuration register, and results are returned through a valid/ready pipeline stage.
module ulut_array #(
  parameter int K  = 2,
  parameter int CH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_en,
  input  logic            cfg_in,
  output logic            cfg_busy,
  output logic            cfg_done,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH*K-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH-1:0]   out_data
);

  localparam int LW = 2 ** K;
  localparam int L  = CH * LW;
  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(L - 1);

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [L-1:0]    cfg_q, cfg_d;
  logic            out_valid_q, out_valid_d;
  logic [CH-1:0]   out_data_q, out_data_d;
  logic            cfg_done_q, cfg_done_d;
  logic            xfer;

  // Channel c reads its own 2^K-entry slice of the configuration, indexed by its select.
  function automatic logic [CH-1:0] lut_eval(input logic [L-1:0] cfg, input logic [CH*K-1:0] sel);
    logic [CH-1:0] res;
    logic [LW-1:0] lut;
    logic [K-1:0]  s;
    res = {CH{1'b0}};
    for (int c = 0; c < CH; c++) begin
      lut    = cfg[c*LW +: LW];
      s      = sel[c*K +: K];
      res[c] = lut[s];
    end
    return res;
  endfunction

  // A configuration bit in flight always wins over data, so input is refused that cycle.
  assign in_ready  = (state_q == RUN) && !cfg_en && (!out_valid_q || out_ready);
  assign xfer      = in_valid && in_ready;
  assign cfg_busy  = (state_q == LOAD);
  assign cfg_done  = cfg_done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Next-state, configuration shift and output-stage handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cfg_d       = cfg_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cfg_done_d  = 1'b0;
    case (state_q)
      UNCFG: begin
        if (cfg_en) begin
          cfg_d   = {cfg_in, cfg_q[L-1:1]};
          cnt_d   = CNT_ONE;
          state_d = LOAD;
        end else begin
          state_d = UNCFG;
        end
      end
      LOAD: begin
        if (cfg_en) begin
          cfg_d = {cfg_in, cfg_q[L-1:1]};
          if (cnt_q == CNT_LAST) begin
            cnt_d      = CNT_ZERO;
            state_d    = RUN;
            cfg_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = LOAD;
        end
      end
      RUN: begin
        if (cfg_en) begin
          // Reconfiguration drops whatever result was waiting for the consumer.
          cfg_d       = {cfg_in, cfg_q[L-1:1]};
          cnt_d       = CNT_ONE;
          state_d     = LOAD;
          out_valid_d = 1'b0;
        end else if (xfer) begin
          out_valid_d = 1'b1;
          out_data_d  = lut_eval(cfg_q, in_data);
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      default: begin
        state_d     = UNCFG;
        cnt_d       = CNT_ZERO;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= UNCFG;
      cnt_q       <= CNT_ZERO;
      cfg_q       <= {L{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {CH{1'b0}};
      cfg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cfg_q       <= cfg_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cfg_done_q  <= cfg_done_d;
    end
  end

endmodule

// File: tb/tb_ulut_array.sv
// Bench for ulut_array (K=2, CH=2). A cycle-level reference model tracks the truth tables
// from the streamed bits and the handshake rules, and every DUT output is compared against it.
module tb_ulut_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_en;
  logic       cfg_in;
  logic       cfg_busy;
  logic       cfg_done;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  localparam int M_UNCFG = 0;
  localparam int M_LOAD  = 1;
  localparam int M_RUN   = 2;

  int       m_mode;
  int       m_cnt;
  bit       m_lut[8];
  bit       m_new[8];
  bit       m_ov;
  bit [1:0] m_od;
  bit       m_done;

  ulut_array #(.K(2), .CH(2)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_in(cfg_in),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Each channel is a 4:1 mux over its four truth-table bits.
  function automatic bit [1:0] ref_out(input logic [3:0] d);
    bit [1:0] r;
    for (int c = 0; c < 2; c++) r[c] = m_lut[c*4 + int'((d >> (2*c)) & 4'd3)];
    return r;
  endfunction

  task automatic model_step(input logic r, input logic ce, input logic ci, input logic iv,
                            input logic [3:0] id, input logic ordy, input bit rdy);
    if (!r) begin
      m_mode = M_UNCFG; m_cnt = 0; m_ov = 1'b0; m_od = 2'b00; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (ce) begin
        if (m_mode != M_LOAD) m_cnt = 0;
        m_new[m_cnt] = ci;
        m_cnt++;
        m_mode = M_LOAD;
        m_ov = 1'b0;
        if (m_cnt == 8) begin
          for (int i = 0; i < 8; i++) m_lut[i] = m_new[i];
          m_mode = M_RUN; m_cnt = 0; m_done = 1'b1;
        end
      end else if (m_mode == M_RUN) begin
        if (iv && rdy) begin
          m_ov = 1'b1; m_od = ref_out(id);
        end else if (m_ov && ordy) begin
          m_ov = 1'b0;
        end
      end
    end
  endtask

  // One clock: drive at posedge+1, check in_ready at negedge, check registered outputs after edge.
  task automatic cyc(input logic r, input logic ce, input logic ci, input logic iv,
                     input logic [3:0] id, input logic ordy);
    bit rdy;
    rst_n = r; cfg_en = ce; cfg_in = ci; in_valid = iv; in_data = id; out_ready = ordy;
    @(negedge clk);
    rdy = (m_mode == M_RUN) && !ce && (!m_ov || ordy);
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    model_step(r, ce, ci, iv, id, ordy, rdy);
    @(posedge clk);
    #1;
    check("cfg_busy", {31'd0, cfg_busy}, {31'd0, m_mode == M_LOAD});
    check("cfg_done", {31'd0, cfg_done}, {31'd0, m_done});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    if (m_ov) check("out_data", {30'd0, out_data}, {30'd0, m_od});
  endtask

  task automatic load(input logic [7:0] bits, input int pause_after, input int pause_len);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, bits[i], 1'b1, 4'($urandom), 1'b1);
      if (i + 1 == pause_after)
        for (int p = 0; p < pause_len; p++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'($urandom), 1'b1);
    end
  endtask

  initial begin
    logic [7:0] bits;
    m_mode = M_UNCFG; m_cnt = 0; m_ov = 1'b0; m_od = 2'b00; m_done = 1'b0;
    for (int i = 0; i < 8; i++) begin m_lut[i] = 1'b0; m_new[i] = 1'b0; end
    rst_n = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_data", {30'd0, out_data}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);

    // Data offered while unconfigured must be ignored.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'($urandom), 1'b1);

    // XOR on channel 0, NOR on channel 1.
    load(8'b0001_0110, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b0011, 1'b1);
    check("xor_nor", {30'd0, out_data}, 32'd2);

    for (int v = 0; v < 16; v++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'(v), 1'b1);

    // Back-pressure then simultaneous drain and accept.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'($urandom), 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);

    // Reconfigure from RUN with a result still pending, pausing after bit 4.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0);
    bits = 8'($urandom);
    load(bits, 4, 5);
    for (int v = 0; v < 16; v++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'(v), 1'b1);

    // Reset part way through a load, then a fresh load.
    bits = 8'($urandom);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, bits[i], 1'b0, 4'd0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
    check("rst_mid_load_busy", {31'd0, cfg_busy}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'($urandom), 1'b1);
    load(8'($urandom), 0, 0);
    for (int v = 0; v < 16; v++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'(v), 1'($urandom));

    // Random traffic, occasional config bits and rare resets.
    for (int n = 0; n < 600; n++) begin
      cyc(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 5) == 0), 1'($urandom),
          1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ulut_array.md
ULUT_ARRAY -- requirements
Module: ulut_array

Interface
REQ-001 The block SHALL have parameter K, default 2, meaning select inputs per channel (1..4).
REQ-002 The block SHALL have parameter CH, default 4, meaning number of independent universal-gate channels (1..16).
REQ-003 The block SHALL define L = CH*2^K, the total configuration length in bits.
REQ-004 Port clk, input, 1, meaning the single rising-edge clock.
REQ-005 Port rst_n, input, 1, meaning synchronous active-low reset, sampled on clk.
REQ-006 Port cfg_en, input, 1, meaning shift one configuration bit this cycle.
REQ-007 Port cfg_in, input, 1, meaning the serial configuration bit.
REQ-008 Port cfg_busy, output, 1, meaning a load is in progress.
REQ-009 Port cfg_done, output, 1, meaning a one-cycle pulse when the final configuration bit is taken.
REQ-010 Port in_valid, input, 1, meaning in_data is valid.
REQ-011 Port in_ready, output, 1, meaning the block accepts in_data this cycle.
REQ-012 Port in_data, input, CH*K, meaning channel c select = in_data[c*K +: K], MSB-first.
REQ-013 Port out_valid, output, 1, meaning out_data is valid.
REQ-014 Port out_ready, input, 1, meaning the consumer accepts out_data.
REQ-015 Port out_data, output, CH, meaning bit c is the result of channel c.

Function
REQ-016 The block SHALL have states UNCFG, LOAD and RUN; reset enters UNCFG.
REQ-017 UNCFG: cfg_en=1 SHALL enter LOAD with the bit counter at 0 and take that bit in the same cycle.
REQ-018 RUN: cfg_en=1 SHALL do the same; out_valid is cleared and pending output is discarded.
REQ-019 LOAD: each cycle with cfg_en=1 SHALL shift cfg_in in at bit L-1 and shift the register right by one; the counter increments.
REQ-020 LOAD: a cycle with cfg_en=0 SHALL hold the register and counter unchanged (pause, no abort).
REQ-021 Counter SHALL be clog2(L+1) bits wide; the first bit streamed ends at cfg bit 0 and the last at bit L-1.
REQ-022 On the cycle the L-th bit is taken, the next state SHALL be RUN and cfg_done SHALL be 1 for exactly the following cycle.
REQ-023 cfg_busy SHALL be 1 exactly while the state is LOAD.
REQ-024 Channel c LUT SHALL be cfg[c*2^K +: 2^K]; result bit = LUT[sel_c].
REQ-025 in_ready SHALL be 1 only in RUN and only when out_valid=0 or out_ready=1 (combinational from those).
REQ-026 Transfer in (in_valid & in_ready) SHALL register the results into out_data and set out_valid on the next edge: latency 1, throughput 1/cycle.
REQ-027 out_valid=1 with out_ready=0 SHALL hold out_data stable.
REQ-028 out_valid & out_ready without a new transfer in SHALL clear out_valid.
REQ-029 A simultaneous output drain and input transfer SHALL keep out_valid=1 and load new data.
REQ-030 cfg_en=1 in the same cycle as in_valid SHALL have priority: the input is not accepted (in_ready=0 that cycle).
REQ-031 in_valid in UNCFG or LOAD SHALL be ignored.

Reset
REQ-032 With rst_n=0 at an edge: state=UNCFG, counter=0, cfg register=0, out_valid=0, out_data=0, cfg_done=0, cfg_busy=0.
REQ-033 in_ready SHALL be 0 during and after reset until a full load completes.
REQ-034 Reset mid-LOAD or mid-handshake SHALL discard all partial configuration and pending output.

Verification (K=2, CH=2, L=8)
REQ-035 Stream cfg bits 0,1,1,0,1,0,0,0 -> cfg_done pulses once one cycle after bit 8; ch0 LUT=0110 (XOR), ch1 LUT=0001 (NOR); in_data=4'b0011 -> out_data=2'b10 one cycle later.
REQ-036 Exhaustive sweep: for all 16 in_data values with out_ready=1, each out_data matches a 4:1 mux reference per channel, with one result per cycle.
REQ-037 Back-pressure: out_ready=0 for 3 cycles -> out_data stable, in_ready=0; release -> drain and accept in the same cycle.
REQ-038 Pause load: cfg_en low for 5 cycles after bit 4 -> cfg_busy stays 1, no cfg_done; resumed bits 5-8 give the same result as an uninterrupted stream.
REQ-039 Reset asserted after 3 config bits -> UNCFG, in_ready=0, out_valid=0; a fresh 8-bit load then works.
REQ-040 cfg_en asserted in RUN with out_valid=1 -> out_valid clears next cycle, cfg_busy=1, in_ready=0 until the new cfg_done.
